comp_nbit_pipe: RTL and testbench
=================================

# comp_nbit_pipe

Parametrised, pipelined magnitude comparator for the floating-point add/sub datapath. It compares two WIDTH-bit operands as unsigned, two's-complement or sign-magnitude values, and reports less/equal/greater. A 4-bit group compare feeds a radix-4 merge tree with one register per level. Operands and an opaque tag flow under a valid/ready handshake, so the block can sit between the unpack and exponent-align stages without external stall logic.

## Interface
- WIDTH, 32, operand width; multiple of 4, range 4..128
- TAG_W, 4, width of the sideband tag carried alongside the operands
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_data_a  in  WIDTH  operand A
- i_data_b  in  WIDTH  operand B
- i_mode  in  2  compare mode: 00 unsigned, 01 two's complement, 10 sign-magnitude, 11 reserved (treated as 00)
- i_tag  in  TAG_W  sideband, returned unmodified with the result
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_less  out  1  A < B
- o_equal  out  1  A == B
- o_greater  out  1  A > B
- o_tag  out  TAG_W  tag of the beat in flight at the output

## Operation
- Geometry: NGRP = WIDTH/4. L = ceil(log4(NGRP)); L = 0 when NGRP = 1.
- Stage 0 (registered):
  - Mode pre-processing:
    - Mode 01 inverts the MSB of both operands, then compares unsigned.
    - Mode 10 masks the MSB (sign) to 0 for the magnitude compare. It registers sign_a, sign_b, and zero_a/zero_b (magnitude == 0).
  - Per group: less_g = a_g < b_g, equal_g = a_g == b_g.
- Merge level k (registered): combine up to 4 adjacent groups, most significant first.
  - less = l3 | e3&l2 | e3&e2&l1 | e3&e2&e1&l0
  - equal = AND of all equals
  - A missing group in a partial set acts as less = 0, equal = 1.
- Final resolve (combinational from the last register):
  - Modes 00/01: direct.
  - Mode 10:
    - Both magnitudes zero → equal, regardless of sign (+0 == −0).
    - Otherwise, signs differ → less = sign_a.
    - Otherwise, both positive → magnitude result.
    - Otherwise, both negative → less = mag_greater, equal = mag_equal.
  - o_greater = ~o_less & ~o_equal.
- Exactly one of o_less/o_equal/o_greater is high whenever o_valid = 1.
- Mode and sign/zero flags and tag travel with their beat through every stage.

## Timing
- Latency: 1 + L cycles from accepted input to o_valid. WIDTH=4 → 1, 8 → 2, 32 → 3, 64 → 3, 128 → 4.
- Accept: a beat is accepted when i_valid & o_ready.
- Output hold: the output beat is held stable while o_valid & ~i_ready.
- Stall: o_ready = ~o_valid | i_ready. When it is low, the whole pipe stalls together; no bubble collapse. Full throughput is 1 beat/cycle with i_ready held high.
- Concurrency: accept and output retire in the same cycle are allowed; the pipe shifts by one.
- Reset values: all stage valids 0, o_valid 0, o_less 0, o_equal 0, o_greater 0, o_tag 0. o_ready = 1 out of reset.
- Reset mid-operation: in-flight beats are discarded and never appear at the output. The first valid output after release comes from a beat accepted after release.
- Inputs are don't-care when i_valid = 0. Stage data registers may update with junk, but their valid stays 0.

## Configuration
- COMP_SIGNMAG_EN defined: mode 10 behaves as described, with the sign/zero flags pipelined.
- COMP_SIGNMAG_EN undefined:
  - Sign/zero flag registers and the resolve logic are removed.
  - Mode 10 is treated as mode 00 (unsigned, full width, MSB not masked).

## Test plan
- WIDTH=32, mode 00, A=0x0000_0010, B=0x0000_0011, i_ready=1 → o_less=1 exactly 3 cycles after accept, o_tag echoed.
- Mode 01, A=0xFFFF_FFFF (−1), B=0x0000_0001 → o_less=1. Swapped operands → o_greater=1. Equal operands → o_equal=1 only.
- COMP_SIGNMAG_EN, mode 10:
  - A=0x8000_0000, B=0x0000_0000 → o_equal=1.
  - A=0xC000_0000, B=0xBF80_0000 → o_less=1.
  - A=0x3F80_0000, B=0xBF80_0000 → o_greater=1.
- Back-to-back 16 beats with i_ready toggling 1-0-0-1 → results in order, no loss or duplication. The output is held stable while stalled, and o_ready deasserts only when o_valid & ~i_ready.
- Assert i_rst_n=0 with 3 beats in flight → o_valid=0 immediately, all outputs 0; no stale beat after release.
- WIDTH=4 and WIDTH=8 builds, exhaustive operand sweep in mode 00 → latency 1 and 2 respectively, results match the reference model.

Source files
------------

// File: rtl/comp_nbit_pipe.sv
// -----------------------------------------------------------------------------
// comp_nbit_pipe
// Pipelined WIDTH-bit magnitude comparator for the FP add/sub datapath.
// Stage 0 compares 4-bit groups and registers per-group less/equal flags.
// Each following level merges up to four adjacent groups with one register per
// level. The less/equal/greater result is resolved combinationally from the
// last register. The whole pipe advances together under a valid/ready
// handshake.
//
// Optional feature macro: COMP_SIGNMAG_EN
//   defined   : mode 2'b10 compares sign-magnitude values (+0 == -0)
//   undefined : mode 2'b10 is an unsigned full-width compare
//
// Parameters
//   WIDTH  operand width, multiple of 4, 4..128
//   TAG_W  sideband tag width
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid / o_ready     input beat handshake
//   i_data_a, i_data_b    operands
//   i_mode                00 unsigned, 01 two's complement, 10 sign-magnitude,
//                         11 unsigned
//   i_tag                 sideband returned with the result
//   o_valid / i_ready     output beat handshake
//   o_less, o_equal,      one-hot result while o_valid
//   o_greater
//   o_tag                 tag of the beat at the output
// -----------------------------------------------------------------------------
module comp_nbit_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic [1:0]       i_mode,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_less,
    output logic             o_equal,
    output logic             o_greater,
    output logic [TAG_W-1:0] o_tag
);

    localparam int NGRP = WIDTH / 4;

    // Number of radix-4 merge levels needed to reduce n groups to one.
    function automatic int calc_levels(input int n);
        int lv;
        int c;
        lv = 0;
        c  = n;
        while (c > 1) begin
            c  = (c + 3) / 4;
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int LVL = calc_levels(NGRP);

    logic             advance_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [NGRP-1:0]  grp_lt_s;
    logic [NGRP-1:0]  grp_eq_s;
    logic [4*NGRP-1:0] pad_lt_s;
    logic [4*NGRP-1:0] pad_eq_s;
    logic [NGRP-1:0]  mrg_lt_s [0:LVL];
    logic [NGRP-1:0]  mrg_eq_s [0:LVL];
    logic             res_lt_s;
    logic             res_eq_s;
    logic             mag_lt_s;
    logic             mag_eq_s;

    // Stage registers: index 0 is the group-compare stage, LVL drives the output.
    logic             valid_r [0:LVL];
    logic [NGRP-1:0]  lt_r    [0:LVL];
    logic [NGRP-1:0]  eq_r    [0:LVL];
    logic [TAG_W-1:0] tag_r   [0:LVL];

`ifdef COMP_SIGNMAG_EN
    logic             is_sm_s;
    logic             zero_a_s;
    logic             zero_b_s;
    logic             sm_r     [0:LVL];
    logic             sign_a_r [0:LVL];
    logic             sign_b_r [0:LVL];
    logic             zero_a_r [0:LVL];
    logic             zero_b_r [0:LVL];
`endif

    // The pipe moves as a unit whenever the output slot is empty or being taken.
    assign advance_s = ~valid_r[LVL] | i_ready;

    // Mode pre-processing: two's complement flips the MSB so an unsigned
    // compare orders it correctly; sign-magnitude drops the sign bit.
    always_comb begin
        op_a_s = i_data_a;
        op_b_s = i_data_b;
        case (i_mode)
            2'b01: begin
                op_a_s[WIDTH-1] = ~i_data_a[WIDTH-1];
                op_b_s[WIDTH-1] = ~i_data_b[WIDTH-1];
            end
`ifdef COMP_SIGNMAG_EN
            2'b10: begin
                op_a_s[WIDTH-1] = 1'b0;
                op_b_s[WIDTH-1] = 1'b0;
            end
`endif
            default: begin
                op_a_s = i_data_a;
                op_b_s = i_data_b;
            end
        endcase
    end

`ifdef COMP_SIGNMAG_EN
    // Sign-magnitude side flags captured alongside the group compare.
    always_comb begin
        is_sm_s  = (i_mode == 2'b10);
        zero_a_s = (i_data_a[WIDTH-2:0] == {(WIDTH-1){1'b0}});
        zero_b_s = (i_data_b[WIDTH-2:0] == {(WIDTH-1){1'b0}});
    end
`endif

    // Per-group 4-bit less/equal compare.
    always_comb begin
        grp_lt_s = {NGRP{1'b0}};
        grp_eq_s = {NGRP{1'b0}};
        for (int g = 0; g < NGRP; g++) begin
            grp_lt_s[g] = (op_a_s[4*g +: 4] <  op_b_s[4*g +: 4]);
            grp_eq_s[g] = (op_a_s[4*g +: 4] == op_b_s[4*g +: 4]);
        end
    end

    // Merge tree: level k folds groups 4j..4j+3 of level k-1, most significant
    // first. Padding with less=0/equal=1 makes missing groups neutral, so
    // unused slots of every level settle to less=0, equal=1 as well.
    always_comb begin
        mrg_lt_s[0] = grp_lt_s;
        mrg_eq_s[0] = grp_eq_s;
        pad_lt_s    = {(4*NGRP){1'b0}};
        pad_eq_s    = {(4*NGRP){1'b1}};
        for (int k = 1; k <= LVL; k++) begin
            pad_lt_s    = {{(3*NGRP){1'b0}}, lt_r[k-1]};
            pad_eq_s    = {{(3*NGRP){1'b1}}, eq_r[k-1]};
            mrg_lt_s[k] = {NGRP{1'b0}};
            mrg_eq_s[k] = {NGRP{1'b1}};
            for (int j = 0; j < NGRP; j++) begin
                for (int i = 3; i >= 0; i--) begin
                    mrg_lt_s[k][j] = mrg_lt_s[k][j] | (mrg_eq_s[k][j] & pad_lt_s[4*j+i]);
                    mrg_eq_s[k][j] = mrg_eq_s[k][j] & pad_eq_s[4*j+i];
                end
            end
        end
    end

    // Pipeline registers for every stage, all enabled by the common advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k <= LVL; k++) begin
                valid_r[k]  <= 1'b0;
                lt_r[k]     <= {NGRP{1'b0}};
                eq_r[k]     <= {NGRP{1'b0}};
                tag_r[k]    <= {TAG_W{1'b0}};
`ifdef COMP_SIGNMAG_EN
                sm_r[k]     <= 1'b0;
                sign_a_r[k] <= 1'b0;
                sign_b_r[k] <= 1'b0;
                zero_a_r[k] <= 1'b0;
                zero_b_r[k] <= 1'b0;
`endif
            end
        end else if (advance_s) begin
            valid_r[0]  <= i_valid;
            tag_r[0]    <= i_tag;
`ifdef COMP_SIGNMAG_EN
            sm_r[0]     <= is_sm_s;
            sign_a_r[0] <= i_data_a[WIDTH-1];
            sign_b_r[0] <= i_data_b[WIDTH-1];
            zero_a_r[0] <= zero_a_s;
            zero_b_r[0] <= zero_b_s;
`endif
            for (int k = 0; k <= LVL; k++) begin
                lt_r[k] <= mrg_lt_s[k];
                eq_r[k] <= mrg_eq_s[k];
            end
            for (int k = 1; k <= LVL; k++) begin
                valid_r[k]  <= valid_r[k-1];
                tag_r[k]    <= tag_r[k-1];
`ifdef COMP_SIGNMAG_EN
                sm_r[k]     <= sm_r[k-1];
                sign_a_r[k] <= sign_a_r[k-1];
                sign_b_r[k] <= sign_b_r[k-1];
                zero_a_r[k] <= zero_a_r[k-1];
                zero_b_r[k] <= zero_b_r[k-1];
`endif
            end
        end
    end

    // Final resolve. Only group 0 of the last level is live; the others are
    // neutral, so reductions over the whole vector give the magnitude result.
    always_comb begin
        mag_lt_s = |lt_r[LVL];
        mag_eq_s = &eq_r[LVL];
        res_lt_s = mag_lt_s;
        res_eq_s = mag_eq_s;
`ifdef COMP_SIGNMAG_EN
        if (sm_r[LVL]) begin
            if (zero_a_r[LVL] & zero_b_r[LVL]) begin
                res_lt_s = 1'b0;
                res_eq_s = 1'b1;
            end else if (sign_a_r[LVL] != sign_b_r[LVL]) begin
                res_lt_s = sign_a_r[LVL];
                res_eq_s = 1'b0;
            end else if (!sign_a_r[LVL]) begin
                res_lt_s = mag_lt_s;
                res_eq_s = mag_eq_s;
            end else begin
                // Both negative: the larger magnitude is the smaller value.
                res_lt_s = ~mag_lt_s & ~mag_eq_s;
                res_eq_s = mag_eq_s;
            end
        end else begin
            res_lt_s = mag_lt_s;
            res_eq_s = mag_eq_s;
        end
`endif
    end

    // Result flags are qualified by valid so idle cycles show all zeros.
    assign o_ready   = advance_s;
    assign o_valid   = valid_r[LVL];
    assign o_less    = valid_r[LVL] & res_lt_s;
    assign o_equal   = valid_r[LVL] & res_eq_s;
    assign o_greater = valid_r[LVL] & ~res_lt_s & ~res_eq_s;
    assign o_tag     = tag_r[LVL];

endmodule

// File: tb/tb_comp_nbit_pipe.sv
// -----------------------------------------------------------------------------
// tb_comp_nbit_pipe
// Drives three comparator instances (WIDTH 32, 8, 4) from one clock. A
// scoreboard per instance holds expected results computed by an arithmetic
// reference model at accept time and compares them when each beat retires.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_comp_nbit_pipe;

    localparam int NDUT = 3;

    typedef struct {
        logic [2:0] res;   // {less, equal, greater}
        logic [3:0] tag;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          pass_cnt;
    int          chk_cnt;

    logic        valid_s  [NDUT];
    logic        ready_s  [NDUT];
    logic [31:0] a_s      [NDUT];
    logic [31:0] b_s      [NDUT];
    logic [1:0]  mode_s   [NDUT];
    logic [3:0]  tag_s    [NDUT];
    logic        ordy_s   [NDUT];
    logic        ovalid_s [NDUT];
    logic        lt_s     [NDUT];
    logic        eq_s     [NDUT];
    logic        gt_s     [NDUT];
    logic [3:0]  otag_s   [NDUT];

    logic        lat_chk  [NDUT];
    logic        held     [NDUT];
    logic [2:0]  held_res [NDUT];
    logic [3:0]  held_tag [NDUT];
    exp_t        sb_q     [NDUT][$];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 32 : ((gi == 1) ? 8 : 4);
        comp_nbit_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_valid   (valid_s[gi]),
            .o_ready   (ordy_s[gi]),
            .i_data_a  (a_s[gi][W-1:0]),
            .i_data_b  (b_s[gi][W-1:0]),
            .i_mode    (mode_s[gi]),
            .i_tag     (tag_s[gi]),
            .o_valid   (ovalid_s[gi]),
            .i_ready   (ready_s[gi]),
            .o_less    (lt_s[gi]),
            .o_equal   (eq_s[gi]),
            .o_greater (gt_s[gi]),
            .o_tag     (otag_s[gi])
        );
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : ((d == 1) ? 8 : 4);
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 2 : 1);
    endfunction

    // Arithmetic reference: convert both operands to integer values per mode.
    function automatic logic [2:0] ref_cmp(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic [1:0] m);
        longint one;
        longint ua;
        longint ub;
        longint va;
        longint vb;
        longint magmask;
        one = 64'sd1;
        ua = 64'sd0;
        ub = 64'sd0;
        ua[31:0] = a;
        ub[31:0] = b;
        ua = ua & ((one << w) - one);
        ub = ub & ((one << w) - one);
        magmask = (one << (w - 1)) - one;
        va = ua;
        vb = ub;
        if (m == 2'b01) begin
            va = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
            vb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        end
`ifdef COMP_SIGNMAG_EN
        if (m == 2'b10) begin
            va = (ua > magmask) ? -(ua & magmask) : ua;
            vb = (ub > magmask) ? -(ub & magmask) : ub;
        end
`endif
        return {va < vb, va == vb, va > vb};
    endfunction

    // Scoreboard: handshake rule, hold stability, one-hot, result and latency.
    task automatic monitor();
        exp_t       e;
        logic [2:0] got;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (!rst_n) begin
                    sb_q[d].delete();
                    held[d] = 1'b0;
                end else begin
                    got = {lt_s[d], eq_s[d], gt_s[d]};
                    chk_cnt++;
                    if (ordy_s[d] !== (!ovalid_s[d] || ready_s[d]))
                        $display("FAIL o_ready dut%0d: got %b want %b", d, ordy_s[d], !ovalid_s[d] || ready_s[d]);
                    else
                        pass_cnt++;
                    if (held[d]) begin
                        chk_cnt++;
                        if (ovalid_s[d] !== 1'b1 || got !== held_res[d] || otag_s[d] !== held_tag[d])
                            $display("FAIL hold dut%0d: got v=%b res=%b tag=%h want v=1 res=%b tag=%h",
                                     d, ovalid_s[d], got, otag_s[d], held_res[d], held_tag[d]);
                        else
                            pass_cnt++;
                    end
                    if (ovalid_s[d]) begin
                        chk_cnt++;
                        if (got !== 3'b100 && got !== 3'b010 && got !== 3'b001)
                            $display("FAIL onehot dut%0d: got %b want exactly one bit", d, got);
                        else
                            pass_cnt++;
                    end
                    if (ovalid_s[d] && ready_s[d]) begin
                        chk_cnt++;
                        if (sb_q[d].size() == 0) begin
                            $display("FAIL unexpected dut%0d: got output res=%b tag=%h want none", d, got, otag_s[d]);
                        end else begin
                            e = sb_q[d].pop_front();
                            if (got !== e.res || otag_s[d] !== e.tag)
                                $display("FAIL result dut%0d: got res=%b tag=%h want res=%b tag=%h",
                                         d, got, otag_s[d], e.res, e.tag);
                            else
                                pass_cnt++;
                            if (lat_chk[d]) begin
                                chk_cnt++;
                                if (cyc - e.cyc != lat_of(d))
                                    $display("FAIL latency dut%0d: got %0d want %0d", d, cyc - e.cyc, lat_of(d));
                                else
                                    pass_cnt++;
                            end
                        end
                    end
                    held[d]     = ovalid_s[d] && !ready_s[d];
                    held_res[d] = got;
                    held_tag[d] = otag_s[d];
                    if (valid_s[d] && ordy_s[d]) begin
                        e.res = ref_cmp(width_of(d), a_s[d], b_s[d], mode_s[d]);
                        e.tag = tag_s[d];
                        e.cyc = cyc;
                        sb_q[d].push_back(e);
                    end
                end
            end
        end
    endtask

    // Present one beat and hold it until the DUT will take it on the next edge.
    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] m, input logic [3:0] t);
        int tries;
        tries = 0;
        @(posedge clk); #1;
        valid_s[d] = 1'b1;
        a_s[d]     = a;
        b_s[d]     = b;
        mode_s[d]  = m;
        tag_s[d]   = t;
        forever begin
            @(negedge clk);
            if (ordy_s[d]) break;
            tries++;
            if (tries > 100) begin
                chk_cnt++;
                $display("FAIL send_timeout dut%0d: got o_ready=0 for %0d cycles want accept", d, tries);
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        @(posedge clk); #1;
        valid_s[d] = 1'b0;
        while ((sb_q[d].size() != 0 || ovalid_s[d]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (sb_q[d].size() != 0)
            $display("FAIL drain dut%0d: got %0d beats pending want 0", d, sb_q[d].size());
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk_cnt++;
            if (ovalid_s[d] !== 1'b0 || lt_s[d] !== 1'b0 || eq_s[d] !== 1'b0 ||
                gt_s[d] !== 1'b0 || otag_s[d] !== 4'h0 || ordy_s[d] !== 1'b1)
                $display("FAIL reset dut%0d: got v=%b l=%b e=%b g=%b tag=%h rdy=%b want 0 0 0 0 0 1",
                         d, ovalid_s[d], lt_s[d], eq_s[d], gt_s[d], otag_s[d], ordy_s[d]);
            else
                pass_cnt++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        lat_chk[0] = 1'b1;
        send(0, 32'h0000_0010, 32'h0000_0011, 2'b00, 4'h5);
        send(0, 32'h0000_0011, 32'h0000_0010, 2'b00, 4'h6);
        send(0, 32'h1234_5678, 32'h1234_5678, 2'b00, 4'h7);
        send(0, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00, 4'h8);
        send(0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 4'h9);
        send(0, 32'h1234_5678, 32'h1234_5679, 2'b00, 4'hA);
        send(0, 32'hF000_0000, 32'h0FFF_FFFF, 2'b00, 4'hB);
        send(0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 4'hC);
        drain(0);
    endtask

    task automatic test_twos();
        lat_chk[0] = 1'b1;
        send(0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 4'h1);
        send(0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b01, 4'h2);
        send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 4'h3);
        send(0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 4'h4);
        send(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 4'h5);
        drain(0);
    endtask

    task automatic test_signmag();
        lat_chk[0] = 1'b1;
        send(0, 32'h8000_0000, 32'h0000_0000, 2'b10, 4'h1);
        send(0, 32'hC000_0000, 32'hBF80_0000, 2'b10, 4'h2);
        send(0, 32'h3F80_0000, 32'hBF80_0000, 2'b10, 4'h3);
        send(0, 32'h3F80_0000, 32'h4000_0000, 2'b10, 4'h4);
        send(0, 32'hBF80_0000, 32'hBF80_0000, 2'b10, 4'h5);
        send(0, 32'h0000_0000, 32'h8000_0001, 2'b10, 4'h6);
        drain(0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [16];
        logic [31:0] tb [16];
        logic [1:0]  tm [16];
        int sent;
        int c;
        lat_chk[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ta[i] = $urandom();
            tb[i] = (i % 3 == 0) ? ta[i] : $urandom();
            tm[i] = 2'($urandom_range(0, 3));
        end
        sent = 0;
        c = 0;
        while ((sent < 16 || sb_q[0].size() != 0) && c < 200) begin
            @(posedge clk); #1;
            ready_s[0] = ((c % 4) == 0) || ((c % 4) == 3);
            if (sent < 16) begin
                valid_s[0] = 1'b1;
                a_s[0]     = ta[sent];
                b_s[0]     = tb[sent];
                mode_s[0]  = tm[sent];
                tag_s[0]   = 4'(sent);
            end else begin
                valid_s[0] = 1'b0;
            end
            @(negedge clk);
            if (valid_s[0] && ordy_s[0]) sent++;
            c++;
        end
        chk_cnt++;
        if (sent != 16)
            $display("FAIL b2b_sent: got %0d accepted want 16", sent);
        else
            pass_cnt++;
        @(posedge clk); #1;
        ready_s[0] = 1'b1;
        drain(0);
    endtask

    task automatic test_reset_midflight();
        lat_chk[0] = 1'b0;
        ready_s[0] = 1'b0;
        for (int i = 0; i < 3; i++)
            send(0, 32'(i + 1), 32'h0000_0005, 2'b00, 4'(i + 1));
        @(posedge clk); #1;
        valid_s[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (ovalid_s[0] !== 1'b0 || lt_s[0] !== 1'b0 || eq_s[0] !== 1'b0 ||
            gt_s[0] !== 1'b0 || otag_s[0] !== 4'h0)
            $display("FAIL midreset: got v=%b l=%b e=%b g=%b tag=%h want all 0",
                     ovalid_s[0], lt_s[0], eq_s[0], gt_s[0], otag_s[0]);
        else
            pass_cnt++;
        ready_s[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (ovalid_s[0] !== 1'b0)
                $display("FAIL stale: got o_valid=%b want 0 after reset", ovalid_s[0]);
            else
                pass_cnt++;
        end
        send(0, 32'h0000_0009, 32'h0000_0002, 2'b00, 4'hE);
        drain(0);
    endtask

    task automatic test_exhaustive();
        lat_chk[1] = 1'b1;
        lat_chk[2] = 1'b1;
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    send(2, 32'(a), 32'(b), 2'(m), 4'(a ^ b));
        drain(2);
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 256; b++)
                send(1, 32'(a), 32'(b), 2'b00, 4'(a + b));
        for (int i = 0; i < 64; i++)
            send(1, $urandom(), $urandom(), 2'($urandom_range(1, 3)), 4'(i));
        drain(1);
    endtask

    // Test sequence; the scoreboard runs alongside for the whole run.
    initial begin
        rst_n    = 1'b0;
        cyc      = 0;
        pass_cnt = 0;
        chk_cnt  = 0;
        for (int d = 0; d < NDUT; d++) begin
            valid_s[d] = 1'b0;
            ready_s[d] = 1'b1;
            a_s[d]     = 32'h0;
            b_s[d]     = 32'h0;
            mode_s[d]  = 2'b00;
            tag_s[d]   = 4'h0;
            lat_chk[d] = 1'b0;
            held[d]    = 1'b0;
        end
        fork
            monitor();
            begin
                test_reset();
                test_unsigned();
                test_twos();
                test_signmag();
                test_back_to_back();
                test_reset_midflight();
                test_exhaustive();
            end
        join_any
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
